rx_fifo: RTL and testbench
==========================

# rx_fifo

Receive-side byte buffer for the UART path, the counterpart of the transmit FIFO. The deserializer pushes each received byte together with its framing/parity status. The host pops entries with a read strobe and gets registered data plus status. The block reports fill level, a threshold flag, a sticky overrun flag and an optional character-timeout flag so the host can service partial bursts.

## Interface
- DEPTH, 16: number of entries; power of two, minimum 4
- THRESH, 8: level at or above which `thresh_hit` asserts; 1..DEPTH
- TIMEOUT, 64: idle cycles before `timeout` asserts; minimum 2

Ports:
- rx_enbl  in  1  clock; all state updates on its rising edge
- areset_n  in  1  asynchronous, active-low reset
- write_en  in  1  push strobe from the receiver
- din  in  8  received byte
- frame_err  in  1  stop-bit error for `din`
- parity_err  in  1  parity error for `din`
- rd_enbl  in  1  pop strobe from the host
- ovr_clr  in  1  clears `overrun`
- dout  out  8  popped byte, registered
- dout_ferr  out  1  `frame_err` stored with `dout`
- dout_perr  out  1  `parity_err` stored with `dout`
- dout_valid  out  1  one-cycle pulse; `dout`/flags updated this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  log2(DEPTH)+1  current level
- thresh_hit  out  1  count >= THRESH
- overrun  out  1  sticky; a push was dropped
- timeout  out  1  character timeout

## Operation
- Storage: DEPTH × 10 bits, holding {parity_err, frame_err, din}. Write pointer and read pointer are log2(DEPTH) bits wide and wrap modulo DEPTH. Level is held in a separate counter.
- Push is accepted when `write_en` is high and either `full` is low, or `full` is high and a pop is accepted in the same cycle. An accepted push writes the entry at the write pointer and increments the write pointer.
- Push while full with no accepted pop: the entry is dropped. Pointers and count are unchanged, and `overrun` is set.
- Pop is accepted when `rd_enbl` is high and `empty` is low. An accepted pop registers the entry at the read pointer onto `dout`/`dout_ferr`/`dout_perr`, increments the read pointer, and drives `dout_valid` = 1 for exactly that next cycle.
- Pop on empty is ignored: `dout` and its flags hold, and `dout_valid` = 0. There is no write-to-read bypass. A push and pop in the same cycle on an empty FIFO accepts only the push.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `overrun` is set by a dropped push and cleared by `ovr_clr`. When both occur in the same cycle, set wins.
- `empty`, `full`, `count` and `thresh_hit` are decoded from the registered count.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge): pointers and count = 0, `dout` = 0x00, `dout_ferr` = `dout_perr` = 0, `dout_valid` = 0, `overrun` = 0, `timeout` = 0, `empty` = 1, `full` = 0, `thresh_hit` = 0. Memory contents are not reset.
- Reset mid-operation discards all entries immediately. The first edge after release sees an empty FIFO.
- Pop latency: the `rd_enbl` edge produces `dout` valid after that same edge, with `dout_valid` high for one cycle.
- Flags reflect the accepted push/pop one edge later. With `full` = 1 and simultaneous push and pop, count stays at DEPTH and `full` stays 1.
- Back-to-back pushes and pops are sustained at one per cycle with no bubbles.

## Configuration
- RX_FIFO_TIMEOUT_EN defined: an idle counter (saturating, log2(TIMEOUT)+1 bits) increments on every edge where the FIFO is non-empty with no accepted push and no accepted pop. The counter clears on an accepted push, an accepted pop, or when the FIFO is empty. `timeout` asserts on the edge where the counter reaches TIMEOUT. It stays high until the next accepted push or pop, or until the FIFO is empty.
- RX_FIFO_TIMEOUT_EN undefined: no counter is built and `timeout` is tied to 0.

## Test plan
- Push 0x11, 0x22, 0x33 with flags 00, 01, 10, then pop ×3 → `dout` 0x11/0x22/0x33 in order with matching `dout_ferr`/`dout_perr`, `dout_valid` one cycle each, `empty` = 1 at the end.
- Push 17 bytes into DEPTH = 16 → `full` = 1, `count` = 16, `overrun` = 1, and the 17th byte absent on drain. Pulse `ovr_clr` → `overrun` = 0. Assert `ovr_clr` during a dropped push → `overrun` stays 1.
- Full FIFO with simultaneous push 0xAA and pop → `count` stays 16, no overrun, 0xAA emerges last on drain. Simultaneous push and pop on empty → `count` = 1, `dout_valid` = 0.
- Push 40 bytes while popping to keep the level between 5 and 10 with THRESH = 8 → pointers wrap and data stays in order. `thresh_hit` tracks `count` >= 8 exactly.
- Macro defined, TIMEOUT = 64: push one byte then idle → `timeout` = 1 after 64 idle edges. A pop clears it and the FIFO becomes empty. Macro undefined → `timeout` stays 0.
- Assert `areset_n` low with 5 entries queued → all outputs at reset values immediately. After release, pop → `dout_valid` = 0.

Source files
------------

// File: rtl/rx_fifo_if.sv
// rtl/rx_fifo_if.sv - Receive FIFO push/pop/status bundle between UART receiver, host and FIFO
interface rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          write_en;
    logic [7:0]    din;
    logic          frame_err;
    logic          parity_err;
    logic          rd_enbl;
    logic          ovr_clr;
    logic [7:0]    dout;
    logic          dout_ferr;
    logic          dout_perr;
    logic          dout_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          thresh_hit;
    logic          overrun;
    logic          timeout;

    // Receiver/host side: drives strobes and data, observes status
    modport master (
        output write_en, din, frame_err, parity_err, rd_enbl, ovr_clr,
        input  dout, dout_ferr, dout_perr, dout_valid,
        input  empty, full, count, thresh_hit, overrun, timeout
    );

    // FIFO side
    modport slave (
        input  write_en, din, frame_err, parity_err, rd_enbl, ovr_clr,
        output dout, dout_ferr, dout_perr, dout_valid,
        output empty, full, count, thresh_hit, overrun, timeout
    );
endinterface

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - UART receive byte FIFO with status, overrun and optional char timeout (RX_FIFO_TIMEOUT_EN)
module rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int THRESH  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       rx_enbl,
    input  logic       areset_n,
    rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    // Each entry is {parity_err, frame_err, data}
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    dout_q;
    logic          ferr_q;
    logic          perr_q;
    logic          valid_q;
    logic          ovr_q;
    logic          timeout_q;

    logic empty_w;
    logic full_w;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);
    assign pop_ok  = bus.rd_enbl && !empty_w;
    // A pop in the same cycle frees the slot a full FIFO needs for the push
    assign push_ok = bus.write_en && (!full_w || pop_ok);
    assign drop    = bus.write_en && !push_ok;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge rx_enbl) begin
        if (push_ok) begin
            mem[wr_ptr] <= {bus.parity_err, bus.frame_err, bus.din};
        end
    end

    // Pointers and level counter
    always_ff @(posedge rx_enbl or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered pop data; holds its value when no pop is accepted
    always_ff @(posedge rx_enbl or negedge areset_n) begin
        if (!areset_n) begin
            dout_q  <= 8'h00;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            if (pop_ok) begin
                {perr_q, ferr_q, dout_q} <= mem[rd_ptr];
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge rx_enbl or negedge areset_n) begin
        if (!areset_n) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

`ifdef RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [TW-1:0] idle_cnt;

    // Idle counter saturates at TIMEOUT; the flag rises on the edge it gets there
    always_ff @(posedge rx_enbl or negedge areset_n) begin
        if (!areset_n) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (push_ok || pop_ok || empty_w) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (idle_cnt != TIMEOUT_C) begin
            idle_cnt <= idle_cnt + TW'(1);
            if (idle_cnt + TW'(1) == TIMEOUT_C) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign timeout_q = 1'b0;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_ferr  = ferr_q;
    assign bus.dout_perr  = perr_q;
    assign bus.dout_valid = valid_q;
    assign bus.empty      = empty_w;
    assign bus.full       = full_w;
    assign bus.count      = count_q;
    assign bus.thresh_hit = (count_q >= THRESH_C);
    assign bus.overrun    = ovr_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - Directed self-checking bench for rx_fifo
module tb_rx_fifo;
    logic clk;
    logic areset_n;
    int   checks;
    int   passed;

    rx_fifo_if #(.DEPTH(16)) bus ();

    rx_fifo #(.DEPTH(16), .THRESH(8), .TIMEOUT(64)) dut (
        .rx_enbl  (clk),
        .areset_n (areset_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one cycle of stimulus, sample 1 time unit after the edge, then idle the inputs
    task automatic step(input logic we, input logic [7:0] d, input logic fe, input logic pe,
                        input logic re, input logic oc);
        bus.write_en   = we;
        bus.din        = d;
        bus.frame_err  = fe;
        bus.parity_err = pe;
        bus.rd_enbl    = re;
        bus.ovr_clr    = oc;
        @(posedge clk);
        #1;
        bus.write_en   = 1'b0;
        bus.din        = 8'h00;
        bus.frame_err  = 1'b0;
        bus.parity_err = 1'b0;
        bus.rd_enbl    = 1'b0;
        bus.ovr_clr    = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},  32'(bus.count), 32'd0);
        chk({tag, "_empty"},  32'(bus.empty), 32'd1);
        chk({tag, "_full"},   32'(bus.full), 32'd0);
        chk({tag, "_thresh"}, 32'(bus.thresh_hit), 32'd0);
        chk({tag, "_dout"},   32'(bus.dout), 32'h00);
        chk({tag, "_ferr"},   32'(bus.dout_ferr), 32'd0);
        chk({tag, "_perr"},   32'(bus.dout_perr), 32'd0);
        chk({tag, "_valid"},  32'(bus.dout_valid), 32'd0);
        chk({tag, "_ovr"},    32'(bus.overrun), 32'd0);
        chk({tag, "_tmo"},    32'(bus.timeout), 32'd0);
    endtask

    initial begin
        logic [9:0] exp_q [$];
        logic [9:0] e;
        int   level;
        int   n_pushed;
        bit   up;
        bit   toggle;
        bit   do_push;
        bit   do_pop;
        logic [7:0] d;

        checks = 0;
        passed = 0;
        bus.write_en   = 1'b0;
        bus.din        = 8'h00;
        bus.frame_err  = 1'b0;
        bus.parity_err = 1'b0;
        bus.rd_enbl    = 1'b0;
        bus.ovr_clr    = 1'b0;

        // Reset values
        areset_n = 1'b0;
        #1;
        chk_reset_state("rst");
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // Three entries with distinct status flags, popped in order
        step(1, 8'h11, 0, 0, 0, 0);
        step(1, 8'h22, 1, 0, 0, 0);
        step(1, 8'h33, 0, 1, 0, 0);
        chk("basic_count", 32'(bus.count), 32'd3);
        chk("basic_valid_idle", 32'(bus.dout_valid), 32'd0);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("pop1_dout", 32'(bus.dout), 32'h11);
        chk("pop1_flags", 32'({bus.dout_perr, bus.dout_ferr}), 32'b00);
        chk("pop1_valid", 32'(bus.dout_valid), 32'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("pop2_dout", 32'(bus.dout), 32'h22);
        chk("pop2_flags", 32'({bus.dout_perr, bus.dout_ferr}), 32'b01);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("pop3_dout", 32'(bus.dout), 32'h33);
        chk("pop3_flags", 32'({bus.dout_perr, bus.dout_ferr}), 32'b10);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("pop_valid_pulse", 32'(bus.dout_valid), 32'd0);
        chk("basic_empty", 32'(bus.empty), 32'd1);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("pop_empty_valid", 32'(bus.dout_valid), 32'd0);
        chk("pop_empty_hold", 32'(bus.dout), 32'h33);

        // Fill past full: 17th byte dropped
        for (int n = 1; n <= 17; n++) begin
            step(1, 8'(8'h40 + n - 1), 0, 0, 0, 0);
            if (n == 7) chk("thresh_at7", 32'(bus.thresh_hit), 32'd0);
            if (n == 8) chk("thresh_at8", 32'(bus.thresh_hit), 32'd1);
            if (n == 16) begin
                chk("fill_full", 32'(bus.full), 32'd1);
                chk("fill_count", 32'(bus.count), 32'd16);
                chk("fill_no_ovr", 32'(bus.overrun), 32'd0);
            end
        end
        chk("drop_ovr", 32'(bus.overrun), 32'd1);
        chk("drop_count", 32'(bus.count), 32'd16);
        chk("drop_full", 32'(bus.full), 32'd1);
        step(1, 8'h51, 0, 0, 0, 1);
        chk("ovr_set_wins", 32'(bus.overrun), 32'd1);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("ovr_clr", 32'(bus.overrun), 32'd0);

        // Full with simultaneous push and pop
        step(1, 8'hAA, 0, 0, 1, 0);
        chk("fullpp_dout", 32'(bus.dout), 32'h40);
        chk("fullpp_count", 32'(bus.count), 32'd16);
        chk("fullpp_full", 32'(bus.full), 32'd1);
        chk("fullpp_ovr", 32'(bus.overrun), 32'd0);
        for (int n = 1; n <= 16; n++) begin
            step(0, 8'h00, 0, 0, 1, 0);
            chk($sformatf("drain%0d", n), 32'(bus.dout), (n == 16) ? 32'hAA : 32'(8'h40 + n));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Push and pop together on empty: only the push is taken
        step(1, 8'h5A, 0, 0, 1, 0);
        chk("emptypp_count", 32'(bus.count), 32'd1);
        chk("emptypp_valid", 32'(bus.dout_valid), 32'd0);
        chk("emptypp_hold", 32'(bus.dout), 32'hAA);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("emptypp_pop", 32'(bus.dout), 32'h5A);
        chk("emptypp_empty", 32'(bus.empty), 32'd1);

        // 40 bytes streamed with the level swinging between 5 and 10
        level = 0;
        n_pushed = 0;
        up = 1'b1;
        toggle = 1'b0;
        while (n_pushed < 40 || level > 0) begin
            if (n_pushed >= 40) begin
                do_push = 1'b0;
                do_pop  = 1'b1;
            end else if (up) begin
                do_push = 1'b1;
                do_pop  = 1'b0;
            end else begin
                do_pop  = 1'b1;
                do_push = toggle;
                toggle  = ~toggle;
            end
            d = 8'(8'hC0 + n_pushed);
            step(do_push, d, 1'(n_pushed), 1'(n_pushed >> 1), do_pop, 0);
            if (do_pop) begin
                e = exp_q.pop_front();
                chk("wrap_dout", 32'({bus.dout_perr, bus.dout_ferr, bus.dout}), 32'(e));
                chk("wrap_valid", 32'(bus.dout_valid), 32'd1);
                level--;
            end
            if (do_push) begin
                exp_q.push_back({1'(n_pushed >> 1), 1'(n_pushed), d});
                n_pushed++;
                level++;
            end
            chk("wrap_count", 32'(bus.count), 32'(level));
            chk("wrap_thresh", 32'(bus.thresh_hit), 32'(level >= 8));
            if (level == 10) up = 1'b0;
            if (level == 5 && n_pushed > 5) up = 1'b1;
        end
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Character timeout
        step(1, 8'h77, 0, 0, 0, 0);
`ifdef RX_FIFO_TIMEOUT_EN
        repeat (63) step(0, 8'h00, 0, 0, 0, 0);
        chk("tmo_63", 32'(bus.timeout), 32'd0);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("tmo_64", 32'(bus.timeout), 32'd1);
        repeat (3) step(0, 8'h00, 0, 0, 0, 0);
        chk("tmo_hold", 32'(bus.timeout), 32'd1);
`else
        repeat (64) step(0, 8'h00, 0, 0, 0, 0);
        chk("tmo_off", 32'(bus.timeout), 32'd0);
`endif
        step(0, 8'h00, 0, 0, 1, 0);
        chk("tmo_pop_dout", 32'(bus.dout), 32'h77);
        chk("tmo_pop_clear", 32'(bus.timeout), 32'd0);
        chk("tmo_pop_empty", 32'(bus.empty), 32'd1);

        // Reset mid-operation with 5 entries queued
        for (int n = 1; n <= 5; n++) step(1, 8'(n), 1, 1, 0, 0);
        step(1, 8'h06, 0, 0, 1, 0);
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        chk("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
        #1;
        areset_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        #2;
        areset_n = 1'b1;
        step(0, 8'h00, 0, 0, 1, 0);
        chk("post_rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("post_rst_dout", 32'(bus.dout), 32'h00);
        chk("post_rst_empty", 32'(bus.empty), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
